// File: rtl/toast_dmem_responder.sv
// Dual-port byte-enabled data memory behind the MEM-stage DMEM interface, with a host/loader port.
// Optional post-reset zero sweep is built when TOAST_DMEM_CLEAR_EN is defined.
module toast_dmem_responder #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] DMEM_addr_i,
    input  logic [3:0]  DMEM_wr_byte_en_i,
    input  logic [31:0] DMEM_wr_data_i,
    input  logic        DMEM_rst_i,
    output logic [31:0] DMEM_rd_data_o,

    input  logic        HOST_req_i,
    input  logic        HOST_we_i,
    input  logic [31:0] HOST_addr_i,
    input  logic [3:0]  HOST_be_i,
    input  logic [31:0] HOST_wdata_i,
    output logic        HOST_ready_o,
    output logic        HOST_rvalid_o,
    output logic [31:0] HOST_rdata_o,

    output logic        init_done_o,
    output logic        oob_err_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t state;

    // NOTE: the storage array has no reset; clearing it is the sweep's job, not rst_i's.
    logic [31:0] mem [DEPTH];

`ifdef TOAST_DMEM_CLEAR_EN
    logic [ADDR_WIDTH-1:0] clr_cnt;
`endif

    logic [ADDR_WIDTH-1:0] a_idx;
    logic [ADDR_WIDTH-1:0] b_idx;
    logic                  a_in_range;
    logic                  b_in_range;
    logic                  live;
    logic                  host_acc;
    logic                  host_rd;
    logic                  host_wr;
    logic [3:0]            a_lane_we;
    logic [3:0]            b_lane_we;
    logic                  unused_addr_lsbs;

    assign a_idx      = DMEM_addr_i[ADDR_WIDTH+1:2];
    assign b_idx      = HOST_addr_i[ADDR_WIDTH+1:2];
    assign a_in_range = (DMEM_addr_i[31:ADDR_WIDTH+2] == '0);
    assign b_in_range = (HOST_addr_i[31:ADDR_WIDTH+2] == '0);

    assign live     = (state == S_IDLE) && !rst_i;
    assign host_acc = HOST_req_i && HOST_ready_o && !rst_i;
    assign host_rd  = host_acc && !HOST_we_i;
    assign host_wr  = host_acc && HOST_we_i;

    assign unused_addr_lsbs = ^{DMEM_addr_i[1:0], HOST_addr_i[1:0]};

    // Per-lane write enables; on a same-word collision the core owns its enabled lanes.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        a_lane_we = '0;
        b_lane_we = '0;
        if (live && a_in_range) begin
            a_lane_we = DMEM_wr_byte_en_i;
        end
        if (host_wr && b_in_range) begin
            b_lane_we = HOST_be_i;
            if (a_idx == b_idx) begin
                b_lane_we = HOST_be_i & ~a_lane_we;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every read of mem in a
    // clocked block sees the pre-edge word -- this is what makes both ports read-first.
    always_ff @(posedge clk_i) begin
`ifdef TOAST_DMEM_CLEAR_EN
        if (state == S_CLEAR && !rst_i) begin
            mem[clr_cnt] <= '0;
        end
`endif
        for (int i = 0; i < 4; i++) begin
            if (b_lane_we[i]) begin
                mem[b_idx][8*i +: 8] <= HOST_wdata_i[8*i +: 8];
            end
            if (a_lane_we[i]) begin
                mem[a_idx][8*i +: 8] <= DMEM_wr_data_i[8*i +: 8];
            end
        end
    end

    // Core read port: one-cycle registered read, zeroed by either reset, the sweep or a bad address.
    always_ff @(posedge clk_i) begin
        if (rst_i || DMEM_rst_i || state != S_IDLE || !a_in_range) begin
            DMEM_rd_data_o <= '0;
        end else begin
            DMEM_rd_data_o <= mem[a_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_CLEAR;
`ifdef TOAST_DMEM_CLEAR_EN
            clr_cnt       <= '0;
`endif
            init_done_o   <= 1'b0;
            HOST_ready_o  <= 1'b0;
            HOST_rvalid_o <= 1'b0;
            HOST_rdata_o  <= '0;
            oob_err_o     <= 1'b0;
        end else begin
            HOST_rvalid_o <= host_rd;
            if (host_rd) begin
                HOST_rdata_o <= b_in_range ? mem[b_idx] : 32'h0;
            end

            // The core port reads every live cycle, so any live out-of-range core address counts.
            if ((live && !a_in_range) || (host_acc && !b_in_range)) begin
                oob_err_o <= 1'b1;
            end

            case (state)
                S_CLEAR: begin
`ifdef TOAST_DMEM_CLEAR_EN
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state        <= S_IDLE;
                        init_done_o  <= 1'b1;
                        HOST_ready_o <= 1'b1;
                    end
`else
                    state        <= S_IDLE;
                    init_done_o  <= 1'b1;
                    HOST_ready_o <= 1'b1;
`endif
                end
                S_IDLE: begin
                    init_done_o  <= 1'b1;
                    HOST_ready_o <= 1'b1;
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toast_dmem_responder.sv
// Directed bench for toast_dmem_responder at ADDR_WIDTH=4; builds with or without TOAST_DMEM_CLEAR_EN.
module tb_toast_dmem_responder;

    localparam int AW = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] DMEM_addr_i;
    logic [3:0]  DMEM_wr_byte_en_i;
    logic [31:0] DMEM_wr_data_i;
    logic        DMEM_rst_i;
    logic [31:0] DMEM_rd_data_o;
    logic        HOST_req_i;
    logic        HOST_we_i;
    logic [31:0] HOST_addr_i;
    logic [3:0]  HOST_be_i;
    logic [31:0] HOST_wdata_i;
    logic        HOST_ready_o;
    logic        HOST_rvalid_o;
    logic [31:0] HOST_rdata_o;
    logic        init_done_o;
    logic        oob_err_o;

    int passed = 0;
    int total  = 0;

    toast_dmem_responder #(.ADDR_WIDTH(AW)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .DMEM_addr_i       (DMEM_addr_i),
        .DMEM_wr_byte_en_i (DMEM_wr_byte_en_i),
        .DMEM_wr_data_i    (DMEM_wr_data_i),
        .DMEM_rst_i        (DMEM_rst_i),
        .DMEM_rd_data_o    (DMEM_rd_data_o),
        .HOST_req_i        (HOST_req_i),
        .HOST_we_i         (HOST_we_i),
        .HOST_addr_i       (HOST_addr_i),
        .HOST_be_i         (HOST_be_i),
        .HOST_wdata_i      (HOST_wdata_i),
        .HOST_ready_o      (HOST_ready_o),
        .HOST_rvalid_o     (HOST_rvalid_o),
        .HOST_rdata_o      (HOST_rdata_o),
        .init_done_o       (init_done_o),
        .oob_err_o         (oob_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] c_addr;
        logic [3:0]  c_be;
        logic [31:0] c_wdata;
        logic        c_rst;
        logic        h_req;
        logic        h_we;
        logic [31:0] h_addr;
        logic [3:0]  h_be;
        logic [31:0] h_wdata;
        logic [31:0] e_rd;
        logic        e_rvalid;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs;
        DMEM_addr_i       = '0;
        DMEM_wr_byte_en_i = '0;
        DMEM_wr_data_i    = '0;
        DMEM_rst_i        = 1'b0;
        HOST_req_i        = 1'b0;
        HOST_we_i         = 1'b0;
        HOST_addr_i       = '0;
        HOST_be_i         = '0;
        HOST_wdata_i      = '0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk_i);
        DMEM_addr_i       = v.c_addr;
        DMEM_wr_byte_en_i = v.c_be;
        DMEM_wr_data_i    = v.c_wdata;
        DMEM_rst_i        = v.c_rst;
        HOST_req_i        = v.h_req;
        HOST_we_i         = v.h_we;
        HOST_addr_i       = v.h_addr;
        HOST_be_i         = v.h_be;
        HOST_wdata_i      = v.h_wdata;
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd"},        DMEM_rd_data_o, 32'h0);
        check({tag, "_ready"},     32'(HOST_ready_o), 32'h0);
        check({tag, "_rvalid"},    32'(HOST_rvalid_o), 32'h0);
        check({tag, "_rdata"},     HOST_rdata_o, 32'h0);
        check({tag, "_init_done"}, 32'(init_done_o), 32'h0);
        check({tag, "_oob"},       32'(oob_err_o), 32'h0);
    endtask

    // Counts edges from reset release until init_done_o; the host may hold a request meanwhile.
    task automatic wait_init(input int exp_n, input string name);
        int n = 0;
        logic seen_rvalid = 1'b0;
        logic seen_ready  = 1'b0;
        while (n < 200) begin
            tick();
            n++;
            if (HOST_rvalid_o) seen_rvalid = 1'b1;
            if (!init_done_o && HOST_ready_o) seen_ready = 1'b1;
            if (init_done_o) break;
        end
        check(name, 32'(n), 32'(exp_n));
        check({name, "_no_accept"}, 32'(seen_rvalid), 32'h0);
        check({name, "_ready_low"}, 32'(seen_ready), 32'h0);
        check({name, "_ready_up"},  32'(HOST_ready_o), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //            c_addr  be    c_wdata      rst  req we h_addr  be    h_wdata       e_rd          rv  e_rdata
        vecs[0]  = '{32'h20, 4'hF, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 32'h0,        32'h00000000, 1'b0, 32'h00000000};
        vecs[1]  = '{32'h20, 4'h4, 32'h00EE0000, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 32'h0,        32'hAABBCCDD, 1'b0, 32'h00000000};
        vecs[2]  = '{32'h20, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 32'h0,        32'hAAEECCDD, 1'b0, 32'h00000000};
        vecs[3]  = '{32'h24, 4'hF, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 32'h0,        32'h00000000, 1'b0, 32'h00000000};
        vecs[4]  = '{32'h24, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 32'h0,        32'h12345678, 1'b0, 32'h00000000};
        vecs[5]  = '{32'h24, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00, 4'h0, 32'h0,        32'h00000000, 1'b0, 32'h00000000};
        vecs[6]  = '{32'h28, 4'hF, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b0, 32'h00, 4'h0, 32'h0,        32'h00000000, 1'b0, 32'h00000000};
        vecs[7]  = '{32'h28, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 32'h0,        32'h0F0F0F0F, 1'b0, 32'h00000000};
        vecs[8]  = '{32'h24, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0,        32'h12345678, 1'b1, 32'hAAEECCDD};
        vecs[9]  = '{32'h20, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h24, 4'h0, 32'h0,        32'hAAEECCDD, 1'b1, 32'h12345678};
        vecs[10] = '{32'h28, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 32'h0,        32'h0F0F0F0F, 1'b0, 32'h12345678};
        vecs[11] = '{32'h30, 4'h3, 32'h0000BEEF, 1'b0, 1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFE1234, 32'h00000000, 1'b0, 32'h12345678};
        vecs[12] = '{32'h30, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0,        32'hCAFEBEEF, 1'b1, 32'hCAFEBEEF};
        vecs[13] = '{32'h20, 4'hF, 32'h11111111, 1'b0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0,        32'hAAEECCDD, 1'b1, 32'hAAEECCDD};
        vecs[14] = '{32'h20, 4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h34, 4'h9, 32'h99000099, 32'h11111111, 1'b0, 32'hAAEECCDD};
        vecs[15] = '{32'h34, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h34, 4'h0, 32'h0,        32'h99000099, 1'b1, 32'h99000099};

        idle_inputs();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_values("reset");

        // Release with a host read pending: it must not be accepted before init_done_o.
        @(negedge clk_i);
        rst_i       = 1'b0;
        HOST_req_i  = 1'b1;
        HOST_addr_i = 32'h0;
`ifdef TOAST_DMEM_CLEAR_EN
        wait_init(16, "init_latency");
`else
        wait_init(1, "init_latency");
`endif
        @(negedge clk_i);
        idle_inputs();
        tick();

`ifndef TOAST_DMEM_CLEAR_EN
        // Without the sweep the array starts undefined, so zero it through the host port.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            HOST_req_i   = 1'b1;
            HOST_we_i    = 1'b1;
            HOST_addr_i  = 32'(i * 4);
            HOST_be_i    = 4'hF;
            HOST_wdata_i = 32'h0;
        end
        @(negedge clk_i);
        idle_inputs();
        tick();
`endif

        // Back-to-back host reads of every word.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            HOST_req_i  = 1'b1;
            HOST_we_i   = 1'b0;
            HOST_addr_i = 32'(i * 4);
            tick();
            check($sformatf("word%0d_rvalid", i), 32'(HOST_rvalid_o), 32'h1);
            check($sformatf("word%0d_rdata", i), HOST_rdata_o, 32'h0);
        end
        @(negedge clk_i);
        idle_inputs();
        tick();

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i]);
            tick();
            check($sformatf("vec%0d_rd", i),     DMEM_rd_data_o, vecs[i].e_rd);
            check($sformatf("vec%0d_rvalid", i), 32'(HOST_rvalid_o), 32'(vecs[i].e_rvalid));
            check($sformatf("vec%0d_rdata", i),  HOST_rdata_o, vecs[i].e_rdata);
            check($sformatf("vec%0d_ready", i),  32'(HOST_ready_o), 32'h1);
            check($sformatf("vec%0d_oob", i),    32'(oob_err_o), 32'h0);
        end

        // Out-of-range core write: 0x40 aliases word 0 at AW=4 but must not touch it.
        @(negedge clk_i);
        idle_inputs();
        DMEM_addr_i       = 32'h40;
        DMEM_wr_byte_en_i = 4'hF;
        DMEM_wr_data_i    = 32'hDEADBEEF;
        tick();
        check("oob_set", 32'(oob_err_o), 32'h1);
        check("oob_core_rd", DMEM_rd_data_o, 32'h0);
        @(negedge clk_i);
        idle_inputs();
        tick();
        check("oob_word0_intact", DMEM_rd_data_o, 32'h0);
        repeat (3) tick();
        check("oob_sticky", 32'(oob_err_o), 32'h1);
        @(negedge clk_i);
        HOST_req_i  = 1'b1;
        HOST_addr_i = 32'h44;
        tick();
        check("oob_host_rvalid", 32'(HOST_rvalid_o), 32'h1);
        check("oob_host_rdata", HOST_rdata_o, 32'h0);
        check("oob_still_set", 32'(oob_err_o), 32'h1);

        // Reset with a core read and host read pending; everything returns to reset values.
        @(negedge clk_i);
        idle_inputs();
        DMEM_addr_i = 32'h20;
        HOST_req_i  = 1'b1;
        HOST_addr_i = 32'h20;
        rst_i       = 1'b1;
        tick();
        check_reset_values("rerst");
        @(negedge clk_i);
        rst_i = 1'b0;
`ifdef TOAST_DMEM_CLEAR_EN
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sweep%0d_rd_forced", i), DMEM_rd_data_o, 32'h0);
            check($sformatf("sweep%0d_ready", i), 32'(HOST_ready_o), 32'h0);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        check("midsweep_init_done", 32'(init_done_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_init(16, "restart_latency");
        tick();
        check("cleared_rvalid", 32'(HOST_rvalid_o), 32'h1);
        check("cleared_rdata", HOST_rdata_o, 32'h0);
        check("cleared_core_rd", DMEM_rd_data_o, 32'h0);
`else
        wait_init(1, "restart_latency");
        tick();
        check("kept_rvalid", 32'(HOST_rvalid_o), 32'h1);
        check("kept_rdata", HOST_rdata_o, 32'h11111111);
        check("kept_core_rd", DMEM_rd_data_o, 32'h11111111);
`endif
        check("final_oob_clear", 32'(oob_err_o), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
